ipsxe_floating_point_lod_norm_v1_0: RTL
=======================================

// Module: ipsxe_floating_point_lod_norm_v1_0
// PURPOSE
//  Pipelined, parametrised leading-one detector and normaliser for the fx2fl path.
//  Takes a fixed-point word (unsigned, or two's complement when SIGNED=1) and splits it into
//  GROUP_W-bit groups. Each group is priority-encoded, then the highest non-zero group is selected.
//  Returns the sign, the leading-one position, the leading-zero count and the left-normalised
//  magnitude, which feed exponent and mantissa formation. Valid/ready streaming with backpressure.
// PARAMETERS
//  DATA_W   32  input width; DATA_W % GROUP_W == 0, DATA_W/GROUP_W >= 2
//  GROUP_W  8   group width, power of 2, >= 2
//  SIGNED   0   0: i_data unsigned; 1: i_data two's complement, magnitude taken first
//  (derived) NGROUP = DATA_W/GROUP_W, POS_W = clog2(DATA_W), GPOS_W = clog2(GROUP_W)
// PORTS
//  i_clk    in   1        clock, all logic rising-edge
//  i_rst    in   1        synchronous reset, active-high
//  i_valid  in   1        input word valid
//  o_ready  out  1        block can accept; transfer when i_valid & o_ready
//  i_data   in   DATA_W   fixed-point input
//  o_valid  out  1        result valid
//  i_ready  in   1        downstream accepts; transfer when o_valid & i_ready
//  o_sign   out  1        sign of input (always 0 when SIGNED=0)
//  o_zero   out  1        magnitude is zero
//  o_pos    out  POS_W    bit index of leading one of magnitude (0 when o_zero)
//  o_lzc    out  POS_W+1  leading-zero count = DATA_W-1-o_pos; DATA_W when o_zero
//  o_norm   out  DATA_W   magnitude << o_lzc (MSB set unless o_zero; 0 when o_zero)
// BEHAVIOUR
//  - Reset: all stage valids 0. o_valid=0. o_sign/o_zero/o_pos/o_lzc/o_norm=0. o_ready=0 while i_rst=1.
//  - Three register stages, fixed latency 3 cycles when not stalled. Throughput 1 word/cycle.
//    S1: register sign and magnitude. SIGNED=1: mag = i_data[MSB] ? -i_data : i_data, as unsigned
//        DATA_W bits. 0x80..0 gives mag 0x80..0 with no overflow. SIGNED=0: mag = i_data, sign=0.
//    S2: per group g, register nz[g] = |grp and gpos[g] = index of highest set bit within the group (GPOS_W bits).
//        Also carry mag forward.
//    S3: select the highest g with nz[g]=1 (strict priority, top group wins).
//        pos = g*GROUP_W + gpos[g], width POS_W. lzc = DATA_W-1-pos. norm = mag << lzc. zero = ~|nz.
//  - Handshake: en = ~s3_valid | i_ready; o_ready = en & ~i_rst. When en=0 every stage holds.
//    o_valid and all result outputs remain stable until accepted. Bubbles advance under en.
//  - Stage valid chain: s1_valid <= i_valid & o_ready; s2/s3 shift under en. No drop, duplication or reorder.
//  - Simultaneous accept-in and accept-out in the same cycle is legal at full rate.
//  - o_valid=1 with i_ready=0 for N cycles: output stable N cycles, input stalled, nothing lost.
//  - Reset mid-operation: in-flight words are discarded. o_valid=0 from the cycle after the reset edge.
//    Nothing from before reset may appear after reset release.
//  - Outputs are registered (S3 registers). o_ready is the only combinational output (i_ready -> o_ready).
// STRUCTURE
//  - Shared include ipsxe_floating_point_fx2fl_defines_v1_0.vh holds the clog2 function and the
//    NGROUP/POS_W derivation macros, for reuse by the exponent/rounding blocks of fx2fl.
//  - Sub-module ipsxe_floating_point_group_enc_v1_0 #(GROUP_W): combinational, outputs nz and gpos.
//    Instantiated NGROUP times in a generate loop feeding the S2 registers.
//  - Group select and shifter are inline in the top-level. The group select is a for-loop priority mux, no casex.
// TESTING (DATA_W=32, GROUP_W=8 unless noted)
//  1 SIGNED=0, i_data=0x0000_0001, i_ready=1 -> 3 cycles later o_pos=0, o_lzc=31, o_norm=0x8000_0000, o_zero=0.
//  2 SIGNED=0, i_data=0x00F0_0000 -> o_pos=23, o_lzc=8, o_norm=0xF000_0000. i_data=0x8000_0000 -> o_pos=31, o_lzc=0.
//  3 SIGNED=1, i_data=0x8000_0000 -> o_sign=1, o_pos=31, o_norm=0x8000_0000.
//    i_data=0xFFFF_FFFF -> o_sign=1, o_pos=0, o_lzc=31. i_data=0x0000_0100 -> o_sign=0, o_pos=8.
//  4 i_data=0 -> o_zero=1, o_pos=0, o_lzc=32, o_norm=0.
//  5 Stream 6 back-to-back words while holding i_ready=0 for cycles 4-5 -> o_ready low exactly those cycles.
//    All 6 results in order, each output stable while stalled, no duplicates.
//  6 Assert i_rst for 1 cycle with 3 words in flight -> o_valid=0 next cycle, all outputs 0.
//    After release, only post-reset words emerge. Close with 10k random words versus a reference model,
//    for SIGNED=0/1 and DATA_W=16/GROUP_W=4.

Source files
------------

// File: rtl/ipsxe_floating_point_lod_norm_v1_0_pkg.sv
// Shared helpers for the fx2fl leading-one detect / normalise path.
package ipsxe_floating_point_lod_norm_v1_0_pkg;

    // Ceiling log2, used to size position and count fields from parameters.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Group count of a word split into equal-width groups.
    function automatic int ngroup(input int data_w, input int group_w);
        return data_w / group_w;
    endfunction

endpackage

// File: rtl/ipsxe_floating_point_group_enc_v1_0.sv
// Combinational priority encoder for one group: nonzero flag plus index of
// the highest set bit.
module ipsxe_floating_point_group_enc_v1_0
    import ipsxe_floating_point_lod_norm_v1_0_pkg::*;
#(
    parameter int  GROUP_W = 8,
    localparam int GPOS_W  = clog2(GROUP_W)
) (
    input  logic [GROUP_W-1:0] grp,
    output logic               nz,
    output logic [GPOS_W-1:0]  gpos
);

    // Ascending scan so the highest set bit is the last one written.
    always_comb begin
        nz   = |grp;
        gpos = '0;
        for (int i = 0; i < GROUP_W; i++) begin
            if (grp[i]) gpos = GPOS_W'(i);
        end
    end

endmodule

// File: rtl/ipsxe_floating_point_lod_norm_v1_0.sv
// Three-stage leading-one detector and left normaliser with valid/ready
// streaming. S1 takes the magnitude, S2 encodes each group, S3 picks the top
// non-zero group and shifts the magnitude up to bit DATA_W-1.
module ipsxe_floating_point_lod_norm_v1_0
    import ipsxe_floating_point_lod_norm_v1_0_pkg::*;
#(
    parameter int  DATA_W  = 32,
    parameter int  GROUP_W = 8,
    parameter int  SIGNED  = 0,
    localparam int POS_W   = clog2(DATA_W)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_sign,
    output logic              o_zero,
    output logic [POS_W-1:0]  o_pos,
    output logic [POS_W:0]    o_lzc,
    output logic [DATA_W-1:0] o_norm
);

    localparam int NGROUP = ngroup(DATA_W, GROUP_W);
    localparam int GPOS_W = clog2(GROUP_W);
    localparam int LZC_W  = POS_W + 1;

    logic              en;
    logic              sign_c;
    logic [DATA_W-1:0] mag_c;

    logic              s1_valid, s1_sign;
    logic [DATA_W-1:0] s1_mag;

    logic [NGROUP-1:0] nz_c;
    logic [GPOS_W-1:0] gpos_c [NGROUP];

    logic              s2_valid, s2_sign;
    logic [DATA_W-1:0] s2_mag;
    logic [NGROUP-1:0] s2_nz;
    logic [GPOS_W-1:0] s2_gpos [NGROUP];

    logic [POS_W-1:0]  pos_c;
    logic [LZC_W-1:0]  lzc_c;
    logic              zero_c;
    logic [DATA_W-1:0] norm_c;

    logic              s3_valid;

    // Whole pipe advances together; a full output stage waiting on downstream freezes everything.
    assign en      = ~s3_valid | i_ready;
    assign o_ready = en & ~i_rst;
    assign o_valid = s3_valid;

    // Magnitude of the input; negating the most negative value wraps to itself, which is the right unsigned magnitude.
    always_comb begin
        sign_c = 1'b0;
        mag_c  = i_data;
        if (SIGNED != 0) begin
            sign_c = i_data[DATA_W-1];
            if (sign_c) mag_c = -i_data;
        end
    end

    // S1: sign and magnitude.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_mag   <= '0;
        end else if (en) begin
            s1_valid <= i_valid & o_ready;
            s1_sign  <= sign_c;
            s1_mag   <= mag_c;
        end
    end

    for (genvar g = 0; g < NGROUP; g++) begin : g_enc
        ipsxe_floating_point_group_enc_v1_0 #(
            .GROUP_W (GROUP_W)
        ) u_enc (
            .grp  (s1_mag[g*GROUP_W +: GROUP_W]),
            .nz   (nz_c[g]),
            .gpos (gpos_c[g])
        );
    end

    // S2: per-group encodings, magnitude carried forward for the shifter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_mag   <= '0;
            s2_nz    <= '0;
            for (int g = 0; g < NGROUP; g++) s2_gpos[g] <= '0;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2_sign  <= s1_sign;
            s2_mag   <= s1_mag;
            s2_nz    <= nz_c;
            for (int g = 0; g < NGROUP; g++) s2_gpos[g] <= gpos_c[g];
        end
    end

    // Group select: ascending loop so the highest non-zero group wins; then count and shift.
    always_comb begin
        pos_c  = '0;
        zero_c = ~|s2_nz;
        for (int g = 0; g < NGROUP; g++) begin
            if (s2_nz[g]) pos_c = POS_W'(g * GROUP_W + int'(s2_gpos[g]));
        end
        if (zero_c) lzc_c = LZC_W'(DATA_W);
        else        lzc_c = LZC_W'(DATA_W - 1) - {1'b0, pos_c};
        norm_c = s2_mag << lzc_c;
    end

    // S3: registered results, held while downstream stalls.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s3_valid <= 1'b0;
            o_sign   <= 1'b0;
            o_zero   <= 1'b0;
            o_pos    <= '0;
            o_lzc    <= '0;
            o_norm   <= '0;
        end else if (en) begin
            s3_valid <= s2_valid;
            o_sign   <= s2_sign;
            o_zero   <= zero_c;
            o_pos    <= pos_c;
            o_lzc    <= lzc_c;
            o_norm   <= norm_c;
        end
    end

endmodule
